// File: rtl/systola_pkg.sv
// rtl/systola_pkg.sv - shared state enum and helpers for the output-stationary array (optional: SYSTOLA_ACC_SAT_EN)
package systola_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} arr_state_e;

  // Number of zero-injection cycles needed for the last beat to reach PE(ROWS-1,COLS-1).
  function automatic int flush_len(input int rows, input int cols);
    return rows + cols - 2;
  endfunction

`ifdef SYSTOLA_ACC_SAT_EN
  // Add two w-bit signed values held in the low bits; clamp on same-sign overflow.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int w);
    logic [63:0] s;
    s = a + b;
    if ((a[w-1] == b[w-1]) && (s[w-1] != a[w-1])) begin
      if (a[w-1]) s = 64'd1 << (w - 1);
      else        s = (64'd1 << (w - 1)) - 64'd1;
    end
    return s;
  endfunction
`endif

endpackage

// File: rtl/mac_pe.sv
// rtl/mac_pe.sv - one signed MAC cell with registered right/down operand pass-through (optional: SYSTOLA_ACC_SAT_EN)
module mac_pe
  import systola_pkg::*;
#(
  parameter int INWIDTH  = 8,
  parameter int OUTWIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       clr,
  input  logic signed [INWIDTH-1:0]  a_in,
  input  logic signed [INWIDTH-1:0]  w_in,
  output logic signed [INWIDTH-1:0]  a_out,
  output logic signed [INWIDTH-1:0]  w_out,
  output logic signed [OUTWIDTH-1:0] acc
);

  logic signed [2*INWIDTH-1:0] prod;
  logic signed [OUTWIDTH-1:0]  prod_ext;
  logic signed [OUTWIDTH-1:0]  acc_sum;

  assign prod     = (2*INWIDTH)'(a_in) * (2*INWIDTH)'(w_in);
  assign prod_ext = OUTWIDTH'(prod);

`ifdef SYSTOLA_ACC_SAT_EN
  logic [63:0] acc64, prod64, sum64;

  // Saturating accumulate: clamp instead of wrapping on overflow.
  always_comb begin
    acc64  = '0;
    prod64 = '0;
    acc64[OUTWIDTH-1:0]  = acc;
    prod64[OUTWIDTH-1:0] = prod_ext;
    sum64   = sat_add(acc64, prod64, OUTWIDTH);
    acc_sum = sum64[OUTWIDTH-1:0];
  end
`else
  // Plain two's-complement accumulate, wraps modulo 2^OUTWIDTH.
  always_comb begin
    acc_sum = acc + prod_ext;
  end
`endif

  // Operands and accumulator only move on an enabled array step; clr restarts the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out <= '0;
      w_out <= '0;
      acc   <= '0;
    end else if (en) begin
      a_out <= a_in;
      w_out <= w_in;
      acc   <= clr ? prod_ext : acc_sum;
    end
  end

endmodule

// File: rtl/pe_arr_os.sv
// rtl/pe_arr_os.sv - output-stationary ROWS x COLS systolic array with skew, flush and row drain (optional: SYSTOLA_ACC_SAT_EN)
module pe_arr_os
  import systola_pkg::*;
#(
  parameter  int ROWS     = 8,
  parameter  int COLS     = 8,
  parameter  int INWIDTH  = 8,
  parameter  int OUTWIDTH = 32,
  localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_last,
  input  logic [ROWS-1:0][INWIDTH-1:0]       in_a,
  input  logic [COLS-1:0][INWIDTH-1:0]       in_w,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [COLS-1:0][OUTWIDTH-1:0]      out_data,
  output logic [RW-1:0]                      out_row,
  output logic                               busy
);

  localparam int FL = flush_len(ROWS, COLS);
  localparam int CW = (FL > 0) ? $clog2(FL + 1) : 1;
  localparam arr_state_e AFTER_LAST = (FL == 0) ? DRAIN : FLUSH;

  arr_state_e state, state_nxt;
  logic [CW-1:0] flush_cnt;
  logic accept, step, clr, flushing;

  logic signed [INWIDTH-1:0]  a_edge [ROWS];
  logic signed [INWIDTH-1:0]  w_edge [COLS];
  logic signed [INWIDTH-1:0]  a_pipe [ROWS][COLS];
  logic signed [INWIDTH-1:0]  w_pipe [ROWS][COLS];
  logic signed [OUTWIDTH-1:0] acc    [ROWS][COLS];

  assign accept   = in_valid && in_ready;
  assign flushing = (state == FLUSH);
  assign step     = accept || flushing;
  assign clr      = accept && (state == IDLE);

  // Next-state decode plus handshake/status outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = in_last ? AFTER_LAST : LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nxt = AFTER_LAST;
      end
      FLUSH: begin
        if (flush_cnt == '0) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && (out_row == RW'(ROWS - 1))) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, flush down-counter and drain row pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
      out_row   <= '0;
    end else begin
      state <= state_nxt;
      if ((state != FLUSH) && (state_nxt == FLUSH)) flush_cnt <= CW'(FL - 1);
      else if (flushing && (flush_cnt != '0))       flush_cnt <= flush_cnt - 1'b1;
      if (out_valid && out_ready)
        out_row <= (out_row == RW'(ROWS - 1)) ? '0 : out_row + 1'b1;
    end
  end

  // Row skew: row i activations are held back i enabled steps; zeros are fed while flushing.
  for (genvar i = 0; i < ROWS; i++) begin : g_skew_a
    logic signed [INWIDTH-1:0] lane;
    assign lane = flushing ? '0 : in_a[i];
    if (i == 0) begin : g_direct
      assign a_edge[i] = lane;
    end else begin : g_delay
      logic signed [INWIDTH-1:0] sr [i];
      // Shift the activation lane by one stage per enabled step.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < i; s++) sr[s] <= '0;
        end else if (step) begin
          sr[0] <= lane;
          for (int s = 1; s < i; s++) sr[s] <= sr[s-1];
        end
      end
      assign a_edge[i] = sr[i-1];
    end
  end

  // Column skew: column j weights are held back j enabled steps.
  for (genvar j = 0; j < COLS; j++) begin : g_skew_w
    logic signed [INWIDTH-1:0] lane;
    assign lane = flushing ? '0 : in_w[j];
    if (j == 0) begin : g_direct
      assign w_edge[j] = lane;
    end else begin : g_delay
      logic signed [INWIDTH-1:0] sr [j];
      // Shift the weight lane by one stage per enabled step.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < j; s++) sr[s] <= '0;
        end else if (step) begin
          sr[0] <= lane;
          for (int s = 1; s < j; s++) sr[s] <= sr[s-1];
        end
      end
      assign w_edge[j] = sr[j-1];
    end
  end

  // PE grid: activations travel right, weights travel down.
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      logic signed [INWIDTH-1:0] a_src, w_src;
      if (j == 0) begin : g_a_edge
        assign a_src = a_edge[i];
      end else begin : g_a_chain
        assign a_src = a_pipe[i][j-1];
      end
      if (i == 0) begin : g_w_edge
        assign w_src = w_edge[j];
      end else begin : g_w_chain
        assign w_src = w_pipe[i-1][j];
      end
      mac_pe #(.INWIDTH(INWIDTH), .OUTWIDTH(OUTWIDTH)) u_pe (
        .clk   (clk),
        .rst   (rst),
        .en    (step),
        .clr   (clr),
        .a_in  (a_src),
        .w_in  (w_src),
        .a_out (a_pipe[i][j]),
        .w_out (w_pipe[i][j]),
        .acc   (acc[i][j])
      );
    end
  end

  // Present the selected accumulator row while draining, zero otherwise.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int r = 0; r < ROWS; r++) begin
        if (out_row == RW'(r)) begin
          for (int c = 0; c < COLS; c++) out_data[c] = acc[r][c];
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_arr_os.sv
// tb/tb_pe_arr_os.sv - randomized model-checked bench for pe_arr_os (2x2/16-bit and 1x1/32-bit instances)
module tb_pe_arr_os;

  localparam int IW  = 8;
  localparam int OWA = 16;
  localparam int OWB = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_busy;
  logic [1:0][IW-1:0]   a_in_a, a_in_w;
  logic [1:0][OWA-1:0]  a_out_data;
  logic [0:0]           a_out_row;

  logic                 b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_busy;
  logic [0:0][IW-1:0]   b_in_a, b_in_w;
  logic [0:0][OWB-1:0]  b_out_data;
  logic [0:0]           b_out_row;

  pe_arr_os #(.ROWS(2), .COLS(2), .INWIDTH(IW), .OUTWIDTH(OWA)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_last(a_in_last),
    .in_a(a_in_a), .in_w(a_in_w), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_row(a_out_row), .busy(a_busy)
  );

  pe_arr_os #(.ROWS(1), .COLS(1), .INWIDTH(IW), .OUTWIDTH(OWB)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_last(b_in_last),
    .in_a(b_in_a), .in_w(b_in_w), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_row(b_out_row), .busy(b_busy)
  );

  int     n_vec = 0;
  int     n_err = 0;
  int     jk;
  int     ja [0:7][0:1];
  int     jw [0:7][0:1];
  longint exp_a [0:1][0:1];
  longint exp_b;
  longint got [0:1][0:1];
  int     row_a = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // C[i][j] = sum over k of A[i][k]*B[k][j], folded into an ow-bit signed accumulator.
  function automatic longint model_c(input int i, input int j, input int ow);
    longint acc, lo, hi;
    acc = 0;
    hi  = (longint'(1) << (ow - 1)) - 1;
    lo  = -hi - 1;
    for (int k = 0; k < jk; k++) begin
      acc = acc + longint'(ja[k][i] * jw[k][j]);
`ifdef SYSTOLA_ACC_SAT_EN
      if (acc > hi) acc = hi;
      else if (acc < lo) acc = lo;
`else
      acc = (acc <<< (64 - ow)) >>> (64 - ow);
`endif
    end
    return acc;
  endfunction

  task automatic load_exp(input bit sel);
    if (sel) exp_b = model_c(0, 0, OWB);
    else for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) exp_a[i][j] = model_c(i, j, OWA);
  endtask

  function automatic bit rdy(input bit sel);
    return sel ? b_in_ready : a_in_ready;
  endfunction

  function automatic bit ov(input bit sel);
    return sel ? b_out_valid : a_out_valid;
  endfunction

  // Every cycle a result row is shown, it must match the model for the expected row.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      row_a = 0;
    end else begin
      if (a_out_valid) begin
        chk("a_out_row", longint'(a_out_row), longint'(row_a));
        for (int j = 0; j < 2; j++)
          chk("a_out_data", longint'($signed(a_out_data[j])), exp_a[row_a][j]);
        if (a_out_ready) row_a = (row_a + 1) % 2;
      end
      if (b_out_valid) begin
        chk("b_out_row", longint'(b_out_row), 0);
        chk("b_out_data", longint'($signed(b_out_data[0])), exp_b);
      end
    end
  end

  task automatic idle_in(input bit sel);
    if (sel) begin
      b_in_valid = 1'b0; b_in_last = 1'b1; b_in_a = 8'($urandom); b_in_w = 8'($urandom);
    end else begin
      a_in_valid = 1'b0; a_in_last = 1'b1; a_in_a = 16'($urandom); a_in_w = 16'($urandom);
    end
  endtask

  // Feed the current job (gapmode 0: none, 1: alternate, 2: random gaps) and check result latency.
  task automatic send_job(input bit sel, input int gapmode, input int fl);
    int lat, ng;
    for (int k = 0; k < jk; k++) begin
      ng = (k == 0) ? 0 : (gapmode == 1) ? 1 : (gapmode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < ng; g++) begin
        idle_in(sel);
        @(negedge clk);
      end
      chk("in_ready_before_beat", longint'(rdy(sel)), 1);
      if (sel) begin
        b_in_valid = 1'b1; b_in_last = (k == jk - 1);
        b_in_a[0] = IW'(ja[k][0]); b_in_w[0] = IW'(jw[k][0]);
      end else begin
        a_in_valid = 1'b1; a_in_last = (k == jk - 1);
        for (int i = 0; i < 2; i++) begin
          a_in_a[i] = IW'(ja[k][i]);
          a_in_w[i] = IW'(jw[k][i]);
        end
      end
      @(negedge clk);
    end
    a_in_valid = 1'b0; a_in_last = 1'b0; b_in_valid = 1'b0; b_in_last = 1'b0;
    lat = 1;
    while (!ov(sel) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("first_out_valid_latency", longint'(lat), longint'(fl + 1));
  endtask

  // Accept all result rows, holding row 0 for stall0 cycles (and random holds when rnd).
  task automatic drain(input bit sel, input int stall0, input bit rnd);
    int rows, hold;
    rows = sel ? 1 : 2;
    for (int r = 0; r < rows; r++) begin
      hold = (r == 0) ? stall0 : (rnd ? int'($urandom_range(0, 2)) : 0);
      if (sel) b_out_ready = 1'b0; else a_out_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (!sel && stall0 == 5 && r == 0) begin
          chk("stall_row", longint'(a_out_row), 0);
          chk("stall_data0", longint'($signed(a_out_data[0])), 19);
          chk("stall_data1", longint'($signed(a_out_data[1])), 22);
        end
      end
      if (sel) begin
        b_out_ready = 1'b1;
        got[0][0] = longint'($signed(b_out_data[0]));
      end else begin
        a_out_ready = 1'b1;
        for (int j = 0; j < 2; j++) got[r][j] = longint'($signed(a_out_data[j]));
      end
      @(negedge clk);
    end
    a_out_ready = 1'b0; b_out_ready = 1'b0;
    chk("in_ready_after_drain", longint'(rdy(sel)), 1);
    chk("out_valid_after_drain", longint'(ov(sel)), 0);
    chk("busy_after_drain", longint'(sel ? b_busy : a_busy), 0);
  endtask

  task automatic set_demo_job();
    jk = 2;
    ja[0][0] = 1; ja[0][1] = 3; ja[1][0] = 2; ja[1][1] = 4;
    jw[0][0] = 5; jw[0][1] = 6; jw[1][0] = 7; jw[1][1] = 8;
  endtask

  task automatic chk_demo();
    chk("c00", got[0][0], 19);
    chk("c01", got[0][1], 22);
    chk("c10", got[1][0], 43);
    chk("c11", got[1][1], 50);
  endtask

  task automatic rand_job(input bit sel, input int maxk);
    jk = int'($urandom_range(1, maxk));
    for (int k = 0; k < jk; k++) begin
      for (int i = 0; i < 2; i++) begin
        ja[k][i] = int'($urandom_range(0, 255)) - 128;
        jw[k][i] = int'($urandom_range(0, 255)) - 128;
      end
    end
    load_exp(sel);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_last = 1'b0; a_in_a = '0; a_in_w = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_last = 1'b0; b_in_a = '0; b_in_w = '0; b_out_ready = 1'b0;
    exp_a = '{default: 0};
    exp_b = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", longint'(a_in_ready), 1);
    chk("rst_out_valid", longint'(a_out_valid), 0);
    chk("rst_out_row", longint'(a_out_row), 0);
    chk("rst_out_data0", longint'(a_out_data[0]), 0);
    chk("rst_out_data1", longint'(a_out_data[1]), 0);
    chk("rst_busy", longint'(a_busy), 0);
    chk("rst_b_in_ready", longint'(b_in_ready), 1);
    chk("rst_b_busy", longint'(b_busy), 0);

    set_demo_job(); load_exp(0);
    send_job(0, 0, 2); drain(0, 0, 0); chk_demo();

    set_demo_job(); load_exp(0);
    send_job(0, 1, 2); drain(0, 0, 0); chk_demo();

    set_demo_job(); load_exp(0);
    send_job(0, 0, 2); drain(0, 5, 0); chk_demo();

    jk = 2;
    for (int k = 0; k < 2; k++) for (int i = 0; i < 2; i++) begin
      ja[k][i] = -128; jw[k][i] = -128;
    end
    load_exp(0);
    send_job(0, 0, 2); drain(0, 0, 0);
    for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++)
`ifdef SYSTOLA_ACC_SAT_EN
      chk("sat_c", got[i][j], 32767);
`else
      chk("wrap_c", got[i][j], -32768);
`endif

    rand_job(0, 4);
    send_job(0, 0, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", longint'(a_out_valid), 0);
    chk("midrst_busy", longint'(a_busy), 0);
    chk("midrst_in_ready", longint'(a_in_ready), 1);
    chk("midrst_out_data0", longint'(a_out_data[0]), 0);
    jk = 1;
    ja[0][0] = 3; ja[0][1] = 3; jw[0][0] = -2; jw[0][1] = -2;
    load_exp(0);
    send_job(0, 0, 2); drain(0, 0, 0);
    for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) chk("post_rst_c", got[i][j], -6);

    jk = 1; ja[0][0] = 7; jw[0][0] = 9;
    load_exp(1);
    send_job(1, 0, 0); drain(1, 0, 0);
    chk("one_by_one_c", got[0][0], 63);

    for (int n = 0; n < 25; n++) begin
      rand_job(0, 6);
      send_job(0, int'($urandom_range(0, 2)), 2);
      drain(0, int'($urandom_range(0, 3)), 1);
    end

    for (int n = 0; n < 10; n++) begin
      rand_job(1, 6);
      send_job(1, int'($urandom_range(0, 2)), 0);
      drain(1, int'($urandom_range(0, 2)), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pe_arr_os.md
Name: pe_arr_os

Overview:
- Parametrised output-stationary systolic array: ROWS x COLS signed MAC PEs.
- Computes one C = A·B tile per job, with A of size ROWS x K and B of size K x COLS; K is set per job by in_last.
- Contains its own input skew, a stall-able valid/ready operand stream, flush control and a row-serial result drain.
- Sits between the operand buffers and the result writeback.

Parameters:
- ROWS, 8, array rows; one activation lane per row.
- COLS, 8, array columns; one weight lane per column.
- INWIDTH, 8, operand width, signed two's complement.
- OUTWIDTH, 32, accumulator and result width; must be >= 2*INWIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  array accepts a beat.
- in_last  in  1  marks the final K beat of the job.
- in_a  in  ROWS x INWIDTH  in_a[i] = A[i][k].
- in_w  in  COLS x INWIDTH  in_w[j] = B[k][j].
- out_valid  out  1  result row valid.
- out_ready  in  1  consumer accepts the result row.
- out_data  out  COLS x OUTWIDTH  out_data[j] = C[out_row][j].
- out_row  out  clog2(ROWS) (min 1)  index of the row being presented.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state = IDLE; all accumulators, skew registers and counters cleared. Outputs after reset: in_ready = 1, out_valid = 0, out_row = 0, out_data = 0, busy = 0.
- Reset mid-job: the job is discarded; partial results are never presented.
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- Beat acceptance: a beat is accepted when in_valid && in_ready. in_ready = 1 in IDLE and LOAD, 0 otherwise.
- IDLE -> LOAD: on the first accepted beat. That same edge zeroes all accumulators and loads product 0, so no clear bubble is needed.
- LOAD -> FLUSH: when an accepted beat carries in_last. If ROWS+COLS-2 = 0, go directly to DRAIN. in_last is ignored unless the beat is accepted.
- A single-beat job (in_last set on the first beat) is legal: IDLE -> FLUSH.
- Array step enable: the array, skew lines and PE operand pipes advance only on an accepted beat, or on every cycle in FLUSH. Gaps in in_valid therefore do not change results.
- Skew and timing: row i activations are delayed i enabled steps; column j weights are delayed j steps. PE(i,j) accumulates beat k on enabled step k+i+j. Operands pass right (a) and down (w) with one register per PE.
- FLUSH: lasts exactly ROWS+COLS-2 cycles and injects zero operands. A down-counter is loaded on entry; the FSM goes to DRAIN when it reaches 0.
- DRAIN:
  - out_valid = 1 with out_row starting at 0.
  - out_data shows accumulator row out_row, registered.
  - On out_valid && out_ready, out_row increments.
  - After the handshake on row ROWS-1: out_valid = 0, out_row = 0, state = IDLE, in_ready = 1 next cycle.
  - While out_ready = 0, out_data and out_row stay stable.
- Arithmetic: the 2*INWIDTH signed product is sign-extended to OUTWIDTH. The accumulator wraps modulo 2^OUTWIDTH.
- Latency: first out_valid arrives 1 + (ROWS+COLS-2) cycles after the cycle in which the in_last beat is accepted.
- No overlap: the next job's beats are not accepted until DRAIN completes.

Optional Feature:
- Macro: SYSTOLA_ACC_SAT_EN.
- Defined: each accumulate saturates to [-2^(OUTWIDTH-1), 2^(OUTWIDTH-1)-1]. Overflow is detected from the sign of the addends versus the sign of the sum.
- Undefined: two's-complement wrap, no saturation logic.

Decomposition:
- Package systola_pkg:
  - state enum arr_state_e {IDLE, LOAD, FLUSH, DRAIN};
  - function flush_len(ROWS, COLS) = ROWS+COLS-2;
  - the saturating-add function, guarded by the macro.
- Sub-module mac_pe (one per PE):
  - inputs: clk, rst, en, clr, a_in, w_in;
  - outputs: a_out, w_out (registered on en), acc.
  - clr with en loads acc = a_in*w_in.
- pe_arr_os holds the FSM, counters, skew lines, drain mux and the generate grid.

Test Plan:
- 2x2, K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]]; beats accepted in cycles 0 and 1 (in_last on 1) -> out_valid rises at cycle 4; row0 = {19,22}, row1 = {43,50}; in_ready = 1 after the row-1 handshake.
- Same job with in_valid low on alternate cycles during LOAD -> identical results; first out_valid 3 cycles after the in_last accept.
- out_ready held 0 for 5 cycles on row 0 -> out_data = {19,22} and out_row = 0 stable throughout; row 1 follows on the cycle after out_ready rises.
- INWIDTH=8, OUTWIDTH=16, K=2, all operands -128 -> without macro, every C = -32768 (wrap); with SYSTOLA_ACC_SAT_EN, every C = 32767.
- rst pulsed while row 0 is presented -> next cycle out_valid = 0, busy = 0, in_ready = 1; a new job 1x1 (A=3, B=-2) yields -6 with no stale data.
- 1x1 array with a single in_last beat (A=7, B=9) -> no FLUSH; out_valid the next cycle with out_data = 63.
